serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial adder/subtractor that takes two WIDTH-bit operands on a start pulse and produces their sum or difference LSB-first, one bit per clock, through a single full-adder cell. It provides the subtract direction alongside the team's 1-bit adder arithmetic. It sits in the datapath wherever area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- sub  input  1  0 = a+b, 1 = a−b; sampled with accepted start
- a  input  WIDTH  operand A; sampled with accepted start
- b  input  WIDTH  operand B; sampled with accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result/cout/ovf valid
- result  output  WIDTH  sum or difference, mod 2^WIDTH
- cout  output  1  add: carry out; sub: 1 when a ≥ b unsigned (no borrow)
- ovf  output  1  signed overflow (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: load shift registers A←a, B←(sub ? ~b : b), carry←sub, bit counter←0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - full_adder_cell computes {c, s} from A[0], B[0], carry.
  - s shifts into result from the MSB end.
  - A and B shift right; carry←c; counter++.
  - When counter reaches WIDTH−1: go to DONE.
- DONE: done=1 for exactly one cycle; cout←final carry; go to IDLE.
- start in RUN or DONE is ignored; it is not queued.
- result, cout and ovf hold their values from the last completed operation until the next accepted start.
  - result is updated bit by bit during RUN and is valid only when done is high or in IDLE afterwards.
- Arithmetic: subtraction is two's complement, a + ~b + 1. All widths are exact WIDTH; there is no sign extension.
- rst at any time, including mid-RUN:
  - next state IDLE.
  - busy=0, done=0, result=0, cout=0, ovf=0, counter=0.
  - Any operation in flight is abandoned.

## Timing
- Accepted start on edge 0: busy=1 from cycle 1 through cycle WIDTH. done=1 in cycle WIDTH+1.
- Latency from start to done: WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is accepted in the cycle after done.
- WIDTH=1: RUN lasts one cycle; done in cycle 2.
- Reset values: busy 0, done 0, result 0, cout 0, ovf 0.

## Configuration
- SERIAL_ADDSUB_OVF_EN
  - Defined: ovf = (carry into MSB) XOR (carry out of MSB), latched on the RUN→DONE transition.
  - Undefined: the port still exists and is tied to 0; no carry-into-MSB register.

## Structure
- Package serial_addsub_pkg:
  - State enum (IDLE, RUN, DONE).
  - Counter width function, clog2(WIDTH).
- Sub-module full_adder_cell: combinational, ports a, b, ci, sum, c; one instance only.
- The shift registers, counter and FSM live in serial_addsub.

## Test plan (WIDTH=8)
- add 3+5 → result 8, cout 0, ovf 0; busy in cycles 1–8, done in cycle 9.
- add 255+1 → result 0, cout 1, ovf 0. add 127+1 → result 128, cout 0, ovf 1 (0 without the macro).
- sub 5−3 → result 2, cout 1. sub 3−5 → result 254, cout 0. sub 128−1 → result 127, ovf 1.
- start 10+20, then start 1+1 in cycle 4 → second start ignored; done in cycle 9 with result 30; result holds through IDLE.
- rst in cycle 4 of a run → next cycle busy 0, done 0, result 0; a fresh start of 7+9 then gives 16 after 9 cycles.
- WIDTH=1 build, all 8 combinations of {a,b,sub} → result/cout match a full adder/subtractor truth table; done in cycle 2.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    // Operation sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; at least one bit so WIDTH=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder_cell.sv
// Single-bit full adder shared by add and subtract.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic c
);

    // Sum and carry of one bit position.
    always_comb begin
        sum = a ^ b ^ ci;
        c   = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// Optional macro SERIAL_ADDSUB_OVF_EN enables signed-overflow reporting;
// without it ovf is tied low.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] result_next;

    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .ci  (carry),
        .sum (fa_s),
        .c   (fa_c)
    );

    // New sum bit enters the result at the MSB end.
    always_comb begin
        result_next            = result >> 1;
        result_next[WIDTH-1]   = fa_s;
    end

    // Sequencer, operand shift registers, carry and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= result_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_c;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf   <= carry ^ fa_c;
`else
                        ovf   <= 1'b0;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8 and WIDTH=1 instances).
module tb_serial_addsub;

    logic       clk;
    logic       rst;
    logic       start, sub;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] result;

    logic       start1, sub1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] result1;

    int checks   = 0;
    int failures = 0;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected ovf depends on the build.
    function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_ADDSUB_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Launch one WIDTH=8 operation from IDLE at a negedge and check the full timeline.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic [7:0] er, input logic ec, input logic eo);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk({tag, "_busy"}, {30'd0, busy, done}, 32'b10);
            if (k < 8) @(negedge clk);
        end
        @(negedge clk);
        chk({tag, "_done"},   {30'd0, busy, done}, 32'b01);
        chk({tag, "_result"}, result, er);
        chk({tag, "_cout"},   cout, ec);
        chk({tag, "_ovf"},    ovf, ovf_exp(eo));
        @(negedge clk);
        chk({tag, "_after"},  {30'd0, busy, done}, 32'b00);
        chk({tag, "_hold"},   result, er);
    endtask

    // Launch one WIDTH=1 operation and check done in cycle 2.
    task automatic run1(input string tag, input logic av, input logic bv, input logic sv,
                        input logic er, input logic ec, input logic eo);
        a1 = av; b1 = bv; sub1 = sv; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk({tag, "_busy"}, {30'd0, busy1, done1}, 32'b10);
        @(negedge clk);
        chk({tag, "_done"},   {30'd0, busy1, done1}, 32'b01);
        chk({tag, "_result"}, result1, er);
        chk({tag, "_cout"},   cout1, ec);
        chk({tag, "_ovf"},    ovf1, ovf_exp(eo));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        chk("rst8", {27'd0, busy, done, cout, ovf, |result}, 32'd0);
        chk("rst1", {27'd0, busy1, done1, cout1, ovf1, result1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle8", {30'd0, busy, done}, 32'd0);

        run8("add3_5",    8'd3,   8'd5, 1'b0, 8'd8,   1'b0, 1'b0);
        run8("add255_1",  8'd255, 8'd1, 1'b0, 8'd0,   1'b1, 1'b0);
        run8("add127_1",  8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
        run8("sub5_3",    8'd5,   8'd3, 1'b1, 8'd2,   1'b1, 1'b0);
        run8("sub3_5",    8'd3,   8'd5, 1'b1, 8'd254, 1'b0, 1'b0);
        run8("sub128_1",  8'd128, 8'd1, 1'b1, 8'd127, 1'b1, 1'b1);
        run8("sub200_200",8'd200, 8'd200,1'b1,8'd0,   1'b1, 1'b0);

        // Second start during RUN is ignored.
        a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
        @(negedge clk);                        // cycle 1
        start = 1'b0;
        repeat (3) @(negedge clk);             // cycle 4
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk);                        // cycle 5
        start = 1'b0;
        chk("ign_busy5", {30'd0, busy, done}, 32'b10);
        repeat (4) @(negedge clk);             // cycle 9
        chk("ign_done", {30'd0, busy, done}, 32'b01);
        chk("ign_result", result, 32'd30);
        repeat (3) @(negedge clk);             // cycle 12, idle
        chk("ign_idle", {30'd0, busy, done}, 32'b00);
        chk("ign_hold", result, 32'd30);

        // Reset mid-run.
        a = 8'd100; b = 8'd50; sub = 1'b0; start = 1'b1;
        @(negedge clk);                        // cycle 1
        start = 1'b0;
        repeat (3) @(negedge clk);             // cycle 4
        rst = 1'b1;
        @(negedge clk);                        // cycle 5
        chk("midrst", {27'd0, busy, done, cout, ovf, |result}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run8("add7_9", 8'd7, 8'd9, 1'b0, 8'd16, 1'b0, 1'b0);

        // WIDTH=1 truth table: a b sub -> result cout ovf.
        run1("w1_a00", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run1("w1_a01", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run1("w1_a10", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run1("w1_a11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run1("w1_s00", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run1("w1_s01", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        run1("w1_s10", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run1("w1_s11", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
